// File: rtl/gpio_pkg.sv
// gpio_pkg: GPIO register offsets shared by the input and output sides
package gpio_pkg;
  localparam logic [11:0] GPIO_SW_VAL  = 12'h024;
  localparam logic [11:0] GPIO_KEY_VAL = 12'h028;
  localparam logic [11:0] GPIO_KEY_PND = 12'h02C;
  localparam logic [11:0] GPIO_IRQ_MSK = 12'h030;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: accepts a key level change only after DEBOUNCE_CYCLES stable cycles
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d, pressed, done;
  always_comb begin
    pressed = ~raw_n;
    done    = (pressed != db_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (pressed == db_q || done) ? '0 : cnt_q + 1'b1;
    db_d    = done ? pressed : db_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end
  assign level = db_q;
  assign rise  = done & ~db_q;
endmodule

// File: rtl/gpio_input.sv
// gpio_input: synchronised switches, debounced keys, W1C key-press pending bits and masked IRQ
module gpio_input
  import gpio_pkg::*;
#(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CS,
  input  logic                REN,
  input  logic                WEN,
  input  logic [11:0]         Addr,
  input  logic [31:0]         DataIn,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [31:0]         DataOut,
  output logic                IRQ
);
  logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q, db, rise;
  logic [NUM_KEYS-1:0] pend_q, pend_d, mask_q, mask_d, clr;
  logic [31:0]         dout_q, dout_d, rdata;
  logic                irq_q, irq_d, rd, wr;
  logic                unused_data;
  assign unused_data = ^DataIn[31:NUM_KEYS];
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw_n (key_s2_q[i]),
      .level (db[i]),
      .rise  (rise[i])
    );
  end
  always_comb begin
    rd     = CS & REN;
    wr     = CS & WEN;
    clr    = (wr && Addr == GPIO_KEY_PND) ? DataIn[NUM_KEYS-1:0] : '0;
    pend_d = (pend_q & ~clr) | rise;
    mask_d = (wr && Addr == GPIO_IRQ_MSK) ? DataIn[NUM_KEYS-1:0] : mask_q;
    rdata  = Addr == GPIO_SW_VAL  ? 32'(sw_s2_q) :
             Addr == GPIO_KEY_VAL ? 32'(db)      :
             Addr == GPIO_KEY_PND ? 32'(pend_q)  :
             Addr == GPIO_IRQ_MSK ? 32'(mask_q)  : '0;
    dout_d = rd ? rdata : dout_q;
    irq_d  = |(pend_q & mask_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      pend_q   <= '0;
      mask_q   <= '0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end
  assign DataOut = dout_q;
  assign IRQ     = irq_q;
endmodule

// File: tb/tb_gpio_input.sv
// tb_gpio_input: directed test of gpio_input against a behavioural model
module tb_gpio_input;
  localparam int D = 4;
  logic        clk, rst, CS, REN, WEN;
  logic [11:0] Addr;
  logic [31:0] DataIn, DataOut, rv;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic        IRQ;
  int          n_tests = 0, n_fail = 0;
  logic        chk_en = 1'b0;
  gpio_input #(.NUM_SW(10), .NUM_KEYS(4), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .CS(CS), .REN(REN), .WEN(WEN), .Addr(Addr),
    .DataIn(DataIn), .SW(SW), .KEY(KEY), .DataOut(DataOut), .IRQ(IRQ)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // Model: pins seen two samples late; a key's accepted level follows the
  // pressed state once it has disagreed for D consecutive samples.
  logic [9:0]  m_sw1, m_sw2;
  logic [3:0]  m_k1, m_k2, m_db, m_pend, m_mask;
  logic [31:0] m_dout;
  logic        m_irq;
  int          m_run[4];
  always @(posedge clk) begin
    automatic logic [3:0]  p;
    automatic logic [3:0]  db;
    automatic logic [3:0]  ev;
    automatic logic [3:0]  clr;
    automatic logic [31:0] rdv;
    p = ~m_k2;
    db = m_db;
    ev = 4'h0;
    if (rst) begin
      m_sw1 <= '0; m_sw2 <= '0; m_k1 <= 4'hF; m_k2 <= 4'hF;
      m_db <= '0; m_pend <= '0; m_mask <= '0; m_dout <= '0; m_irq <= 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (p[i] == m_db[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 == D) begin
          db[i] = p[i];
          ev[i] = p[i];
          m_run[i] <= 0;
        end else m_run[i] <= m_run[i] + 1;
      end
      case (Addr)
        12'h024: rdv = {22'b0, m_sw2};
        12'h028: rdv = {28'b0, m_db};
        12'h02C: rdv = {28'b0, m_pend};
        12'h030: rdv = {28'b0, m_mask};
        default: rdv = 32'h0;
      endcase
      clr = (CS && WEN && Addr == 12'h02C) ? DataIn[3:0] : 4'h0;
      if (CS && REN) m_dout <= rdv;
      if (CS && WEN && Addr == 12'h030) m_mask <= DataIn[3:0];
      m_pend <= (m_pend & ~clr) | ev;
      m_irq <= |(m_pend & m_mask);
      m_db <= db;
      m_sw1 <= SW; m_sw2 <= m_sw1;
      m_k1 <= KEY; m_k2 <= m_k1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("model_dout", DataOut, m_dout);
    chk("model_irq", {31'b0, IRQ}, {31'b0, m_irq});
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    CS = 1'b1; REN = 1'b1; Addr = a;
    @(negedge clk);
    d = DataOut;
    CS = 1'b0; REN = 1'b0;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    CS = 1'b1; WEN = 1'b1; Addr = a; DataIn = v;
    @(negedge clk);
    CS = 1'b0; WEN = 1'b0; DataIn = '0;
  endtask
  initial begin
    rst = 1'b1; CS = 1'b0; REN = 1'b0; WEN = 1'b0; Addr = '0; DataIn = '0;
    SW = '0; KEY = 4'hF;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_dout", DataOut, 32'h0);
    chk("reset_irq", {31'b0, IRQ}, 32'h0);
    rd(12'h02C, rv); chk("reset_pnd", rv, 32'h0);
    rd(12'h030, rv); chk("reset_msk", rv, 32'h0);
    SW = 10'h2A5;
    tick(3);
    rd(12'h024, rv); chk("sw_val", rv, 32'h2A5);
    KEY[1] = 1'b0; tick(3); KEY[1] = 1'b1; tick(8);
    rd(12'h028, rv); chk("glitch_keyval", rv, 32'h0);
    rd(12'h02C, rv); chk("glitch_pnd", rv, 32'h0);
    KEY[1] = 1'b0; tick(8);
    rd(12'h028, rv); chk("press_keyval", rv, 32'h2);
    rd(12'h02C, rv); chk("press_pnd", rv, 32'h2);
    KEY[1] = 1'b1; tick(8);
    rd(12'h028, rv); chk("release_keyval", rv, 32'h0);
    rd(12'h02C, rv); chk("release_pnd_kept", rv, 32'h2);
    wr(12'h02C, 32'hF);
    wr(12'h030, 32'h2);
    tick(1);
    chk("irq_idle", {31'b0, IRQ}, 32'h0);
    KEY[1] = 1'b0;
    tick(6); chk("irq_pend_set", {31'b0, IRQ}, 32'h0);
    tick(1); chk("irq_raised", {31'b0, IRQ}, 32'h1);
    wr(12'h02C, 32'h2);
    chk("irq_lag", {31'b0, IRQ}, 32'h1);
    tick(1); chk("irq_cleared", {31'b0, IRQ}, 32'h0);
    rd(12'h02C, rv); chk("pnd_w1c", rv, 32'h0);
    KEY[1] = 1'b1; tick(8);
    wr(12'h030, 32'h0);
    KEY[3] = 1'b0; tick(10);
    rd(12'h02C, rv); chk("masked_pnd", rv, 32'h8);
    chk("masked_irq", {31'b0, IRQ}, 32'h0);
    KEY[3] = 1'b1; tick(8);
    wr(12'h02C, 32'hF);
    KEY[0] = 1'b0; tick(5);
    wr(12'h02C, 32'h1);
    rd(12'h02C, rv); chk("set_beats_clear", rv, 32'h1);
    rd(12'h02C, rv); chk("read_no_clear", rv, 32'h1);
    KEY[0] = 1'b1; tick(8);
    wr(12'h02C, 32'hF);
    wr(12'h030, 32'h4);
    KEY[2] = 1'b0; tick(8);
    wr(12'h02C, 32'hF);
    rst = 1'b1; tick(1); rst = 1'b0;
    rd(12'h028, rv); chk("rst_keyval", rv, 32'h0);
    tick(10);
    rd(12'h028, rv); chk("rst_repress_keyval", rv, 32'h4);
    rd(12'h02C, rv); chk("rst_repress_pnd", rv, 32'h4);
    chk("rst_mask_irq", {31'b0, IRQ}, 32'h0);
    KEY[2] = 1'b1; tick(8);
    rd(12'h040, rv); chk("unmapped_rd", rv, 32'h0);
    wr(12'h024, 32'hFFFF_FFFF);
    wr(12'h040, 32'hFFFF_FFFF);
    rd(12'h024, rv); chk("ro_sw", rv, 32'h2A5);
    rd(12'h030, rv); chk("unmapped_wr_msk", rv, 32'h0);
    rd(12'h02C, rv); chk("unmapped_wr_pnd", rv, 32'h4);
    tick(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
